// File: rtl/cmp_pkg.sv
// cmp_pkg: shared types and widths for the cmp_sampler_array block
package cmp_pkg;
    typedef enum logic [1:0] {IDLE, PRE, EVAL, LATCH} state_e;
    localparam int CNT_W = 4;
    localparam int TIE_W = 8;
endpackage

// File: rtl/cmp_chan_filter.sv
// cmp_chan_filter: per-channel consecutive-agreement decision filter
//   in : clk, rst_n (async active-low), latch (sample strobe), d (sample), tie (sample is a tie), clr
//   out: out (committed decision), valid (committed since reset/clr), commit (out/valid update this cycle)
module cmp_chan_filter
    import cmp_pkg::*;
#(
    parameter int FILT = 3
) (
    input  logic clk,
    input  logic rst_n,
    input  logic latch,
    input  logic d,
    input  logic tie,
    input  logic clr,
    output logic out,
    output logic valid,
    output logic commit
);
    localparam logic [CNT_W-1:0] FILT_C = CNT_W'(FILT);

    logic             cand_q, cand_d, out_q, out_d, valid_q, valid_d, upd;
    logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;

    always_comb begin
        upd     = latch && !tie;
        cnt_inc = (cnt_q >= FILT_C) ? FILT_C : cnt_q + 1'b1;
        cand_d  = clr ? 1'b0 : upd ? d : cand_q;
        cnt_d   = clr ? '0 : !upd ? cnt_q : (d == cand_q) ? cnt_inc : CNT_W'(1);
        // clr wins over a commit landing on the same cycle
        commit  = !clr && upd && (cnt_d == FILT_C) && (cand_d != out_q || !valid_q);
        out_d   = clr ? 1'b0 : commit ? cand_d : out_q;
        valid_d = clr ? 1'b0 : commit ? 1'b1 : valid_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cand_q  <= 1'b0;
            cnt_q   <= '0;
            out_q   <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            cand_q  <= cand_d;
            cnt_q   <= cnt_d;
            out_q   <= out_d;
            valid_q <= valid_d;
        end
    end

    assign out   = out_q;
    assign valid = valid_q;
endmodule

// File: rtl/cmp_sampler_array.sv
// cmp_sampler_array: multi-channel clocked comparator sampler with tie rejection and debounce
//   in : clk, rst_n (async active-low), en, clr, vip[NCH], vin[NCH] (asynchronous)
//   out: out[NCH], valid[NCH], chg (any change/valid rise), busy (sequencer active), tie_cnt[8]
//   Optional macro CMP_TIE_CNT_EN enables the saturating tie counter; otherwise tie_cnt is 0.
module cmp_sampler_array
    import cmp_pkg::*;
#(
    parameter int NCH  = 2,
    parameter int FILT = 3,
    parameter int DIV  = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             clr,
    input  logic [NCH-1:0]   vip,
    input  logic [NCH-1:0]   vin,
    output logic [NCH-1:0]   out,
    output logic [NCH-1:0]   valid,
    output logic             chg,
    output logic             busy,
    output logic [TIE_W-1:0] tie_cnt
);
    state_e         state_q, state_d;
    logic [3:0]     div_q, div_d;
    logic [NCH-1:0] vip_m_q, vip_s_q, vin_m_q, vin_s_q, tie, commit;
    logic           chg_q, chg_d, latch;

    always_comb begin
        state_d = state_q;
        div_d   = div_q;
        unique case (state_q)
            IDLE:  state_d = en ? PRE : IDLE;
            PRE: begin
                state_d = EVAL;
                div_d   = '0;
            end
            EVAL: begin
                state_d = (div_q == 4'(DIV - 3)) ? LATCH : EVAL;
                div_d   = div_q + 1'b1;
            end
            LATCH: state_d = en ? PRE : IDLE;
            default: state_d = IDLE;
        endcase
        latch = (state_q == LATCH);
        tie   = ~(vip_s_q ^ vin_s_q);
        chg_d = |commit;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            div_q   <= '0;
            vip_m_q <= '0;
            vip_s_q <= '0;
            vin_m_q <= '0;
            vin_s_q <= '0;
            chg_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            div_q   <= div_d;
            vip_m_q <= vip;
            vip_s_q <= vip_m_q;
            vin_m_q <= vin;
            vin_s_q <= vin_m_q;
            chg_q   <= chg_d;
        end
    end

    for (genvar g = 0; g < NCH; g++) begin : g_ch
        cmp_chan_filter #(.FILT(FILT)) u_filt (
            .clk    (clk),
            .rst_n  (rst_n),
            .latch  (latch),
            .d      (vip_s_q[g]),
            .tie    (tie[g]),
            .clr    (clr),
            .out    (out[g]),
            .valid  (valid[g]),
            .commit (commit[g])
        );
    end

`ifdef CMP_TIE_CNT_EN
    logic [TIE_W-1:0] tie_q, tie_d;

    always_comb
        tie_d = clr ? '0 : (latch && |tie && tie_q != '1) ? tie_q + 1'b1 : tie_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) tie_q <= '0;
        else        tie_q <= tie_d;
    end

    assign tie_cnt = tie_q;
`else
    assign tie_cnt = '0;
`endif

    assign chg  = chg_q;
    assign busy = (state_q != IDLE);
endmodule

// File: tb/tb_cmp_sampler_array.sv
// tb_cmp_sampler_array: directed self-checking bench for cmp_sampler_array (NCH=2, FILT=3, DIV=4)
module tb_cmp_sampler_array;
    logic       clk, rst_n, en, clr, chg, busy;
    logic [1:0] vip, vin, out, valid;
    logic [7:0] tie_cnt;
    int         n_vec = 0;
    int         n_err = 0;

`ifdef CMP_TIE_CNT_EN
    localparam logic [7:0] TIE_EXP = 8'd5;
`else
    localparam logic [7:0] TIE_EXP = 8'd0;
`endif

    cmp_sampler_array #(.NCH(2), .FILT(3), .DIV(4)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .en      (en),
        .clr     (clr),
        .vip     (vip),
        .vin     (vin),
        .out     (out),
        .valid   (valid),
        .chg     (chg),
        .busy    (busy),
        .tie_cnt (tie_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_vec++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    initial begin
        rst_n = 1'b1;
        en    = 1'b0;
        clr   = 1'b0;
        vip   = 2'($urandom);
        vin   = 2'($urandom);
        #2 rst_n = 1'b0;
        repeat (3) begin
            tick();
            vip = 2'($urandom);
            vin = 2'($urandom);
        end
        check("rst_out", 8'(out), 8'd0);
        check("rst_valid", 8'(valid), 8'd0);
        check("rst_chg", 8'(chg), 8'd0);
        check("rst_busy", 8'(busy), 8'd0);
        check("rst_tie", tie_cnt, 8'd0);

        // ch0 decides 1, ch1 decides 0; let the synchronizers settle in IDLE
        @(negedge clk);
        rst_n = 1'b1;
        vip   = 2'b01;
        vin   = 2'b10;
        repeat (3) tick();
        en = 1'b1;
        for (int i = 1; i <= 14; i++) begin
            tick();
            check("first_chg", 8'(chg), 8'(i == 13));
            check("first_busy", 8'(busy), 8'd1);
            if (i == 13) begin
                check("first_out", 8'(out), 8'b01);
                check("first_valid", 8'(valid), 8'b11);
            end
            if (i == 14) begin
                vip = 2'b00;
                vin = 2'b11;
            end
        end

        // one inverted sample on ch0 (LATCH 16), restored before LATCH 20
        for (int i = 15; i <= 30; i++) begin
            tick();
            if (i == 18) begin
                vip = 2'b01;
                vin = 2'b10;
            end
            check("glitch_chg", 8'(chg), 8'd0);
            check("glitch_out", 8'(out), 8'b01);
        end

        // ch1 ties on LATCH 32,36,40,44,48
        vip = 2'b11;
        vin = 2'b10;
        for (int i = 31; i <= 53; i++) begin
            tick();
            if (i == 49) begin
                vip = 2'b01;
                vin = 2'b10;
            end
            check("tie_chg", 8'(chg), 8'd0);
            check("tie_out", 8'(out), 8'b01);
            check("tie_valid", 8'(valid), 8'b11);
            if (i == 49 || i == 53) check("tie_cnt", tie_cnt, TIE_EXP);
            if (i == 53) clr = 1'b1;
        end

        // cycle 54: cleared, drop en during EVAL; LATCH 56 still counts
        tick();
        clr = 1'b0;
        en  = 1'b0;
        check("clr_out", 8'(out), 8'd0);
        check("clr_valid", 8'(valid), 8'd0);
        check("clr_tie", tie_cnt, 8'd0);
        check("clr_busy", 8'(busy), 8'd1);
        tick();
        check("drop_busy55", 8'(busy), 8'd1);
        tick();
        check("drop_busy56", 8'(busy), 8'd1);
        tick();
        check("drop_busy57", 8'(busy), 8'd0);
        check("drop_valid57", 8'(valid), 8'd0);
        tick();
        check("drop_busy58", 8'(busy), 8'd0);
        en = 1'b1;
        // two more samples complete the filter only if LATCH 56 was counted
        for (int j = 1; j <= 9; j++) begin
            tick();
            check("resume_chg", 8'(chg), 8'(j == 9));
            check("resume_busy", 8'(busy), 8'd1);
            if (j == 9) begin
                check("resume_out", 8'(out), 8'b01);
                check("resume_valid", 8'(valid), 8'b11);
            end
        end

        // clr in cycle 67, then LATCH 70 and 74 bring cnt to 2
        clr = 1'b1;
        tick();
        clr = 1'b0;
        check("clr2_out", 8'(out), 8'd0);
        check("clr2_valid", 8'(valid), 8'd0);
        repeat (8) tick();
        rst_n = 1'b0;
        #1;
        check("midrst_busy", 8'(busy), 8'd0);
        check("midrst_out", 8'(out), 8'd0);
        check("midrst_valid", 8'(valid), 8'd0);
        check("midrst_chg", 8'(chg), 8'd0);
        check("midrst_tie", tie_cnt, 8'd0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int j = 1; j <= 13; j++) begin
            tick();
            check("post_chg", 8'(chg), 8'(j == 13));
            if (j == 12) check("post_valid12", 8'(valid), 8'd0);
            if (j == 13) begin
                check("post_out", 8'(out), 8'b01);
                check("post_valid", 8'(valid), 8'b11);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
